// File: rtl/mux16_rr_arbiter.sv
// rtl/mux16_rr_arbiter.sv - round-robin owner arbiter driving the select of a shared 16:1 mux
// One owner at a time, bounded burst under contention, rotating priority pointer.
module mux16_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  output logic [15:0] grant,
  output logic        gnt_valid,
  output logic [3:0]  gnt_idx,
  output logic [3:0]  sel,
  output logic        gnt_new
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t        state_q;
  logic [15:0]   grant_q;
  logic          valid_q;
  logic [3:0]    idx_q;
  logic [3:0]    sel_q;
  logic          new_q;
  logic [3:0]    ptr_q;
  logic [CW-1:0] hold_q;

  logic [15:0]   others;
  logic          others_any;
  logic [4:0]    pick_idle;
  logic [4:0]    pick_next;

  // Returns {found, index} of the first set bit of m scanning start, start+1, ... mod 16.
  function automatic logic [4:0] rr_pick(input logic [15:0] m, input logic [3:0] start);
    logic [4:0] r;
    logic [3:0] i;
    r = '0;
    for (int k = 15; k >= 0; k--) begin
      i = start + 4'(k);
      if (m[i]) r = {1'b1, i};
    end
    return r;
  endfunction

  always_comb begin
    others     = req & ~(16'h0001 << idx_q);
    others_any = |others;
    pick_idle  = rr_pick(req, ptr_q);
    // Outgoing owner is masked and the scan starts just past it, so it ranks last.
    pick_next  = rr_pick(others, idx_q + 4'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      sel_q   <= 4'hF;
      new_q   <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      new_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_idle[4]) begin
            state_q <= GRANT;
            grant_q <= 16'h0001 << pick_idle[3:0];
            valid_q <= 1'b1;
            idx_q   <= pick_idle[3:0];
            sel_q   <= 4'hF - pick_idle[3:0];
            new_q   <= 1'b1;
            hold_q  <= '0;
          end
        end
        GRANT: begin
          if (!req[idx_q] || (hold_q == HOLD_LAST && others_any)) begin
            ptr_q <= idx_q + 4'd1;
            if (pick_next[4]) begin
              grant_q <= 16'h0001 << pick_next[3:0];
              idx_q   <= pick_next[3:0];
              sel_q   <= 4'hF - pick_next[3:0];
              new_q   <= 1'b1;
              hold_q  <= '0;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
              valid_q <= 1'b0;
            end
          end else if (hold_q == HOLD_LAST) begin
            hold_q <= '0;
          end else begin
            hold_q <= hold_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign gnt_valid = valid_q;
  assign gnt_idx   = idx_q;
  assign sel       = sel_q;
  assign gnt_new   = new_q;

`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_valid:  assert property (@(posedge clk) disable iff (rst) gnt_valid == (|grant));
  a_owner:  assert property (@(posedge clk) disable iff (rst) gnt_valid |-> grant[gnt_idx]);
  a_sel:    assert property (@(posedge clk) disable iff (rst) ({1'b0, sel} + {1'b0, gnt_idx}) == 5'd15);
  a_new:    assert property (@(posedge clk) disable iff (rst) gnt_new |-> gnt_valid);
`endif

endmodule
